// File: rtl/cpu_seq_pkg.sv
// Shared types and constants for the instruction sequencer.
// Phase strobe bit positions, sequencer state encoding, address width.
// Helper maps a sequencer state to its one-hot phase strobe pattern.
package cpu_seq_pkg;

  localparam int ADDR_W = 32;

  // Bit positions inside the start[3:0] phase strobe vector
  localparam int PH_FETCH  = 0;
  localparam int PH_DECODE = 1;
  localparam int PH_EXEC   = 2;
  localparam int PH_PC     = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_SETUP  = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  // SETUP deliberately has no strobe: it gives pc_o/pc_update a full cycle
  // of setup before the PC-update strobe rises in WB.
  function automatic logic [3:0] phase_strobe(input state_t s);
    logic [3:0] st;
    st = 4'b0000;
    case (s)
      ST_FETCH:  st[PH_FETCH]  = 1'b1;
      ST_DECODE: st[PH_DECODE] = 1'b1;
      ST_EXEC:   st[PH_EXEC]   = 1'b1;
      ST_WB:     st[PH_PC]     = 1'b1;
      default:   st = 4'b0000;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/cpu_sequencer.sv
// Purpose: per-instruction phase sequencer (fetch/decode/exec/setup/wb) with halt, branch redirect and retire count.
// Latency: 5 clk per instruction, outputs registered from the next-state decode (visible in the state they describe).
// Backpressure: none; run/step are accepted only in IDLE or at WB, HALT is left only through rst_n.
module cpu_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              step,
  input  logic              halt_req,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [3:0]        start,
  output logic              pc_update,
  output logic [ADDR_W-1:0] pc_o,
  output logic              busy,
  output logic              halted,
  output logic [CNT_W-1:0]  retired
);

  state_t state_q;
  state_t state_d;
  logic   halt_flag_q;
  logic   enter_fetch;
  logic   sample_halt;

  // Every non-IDLE/HALT state is a single cycle, so moving into FETCH is
  // always an entry event.
  assign enter_fetch = (state_d == ST_FETCH);
  assign sample_halt = (state_q == ST_DECODE) || (state_q == ST_EXEC);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: fixed phase chain, decision point at WB
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (run || step) state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC:   state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_WB;
      ST_WB: begin
        if (halt_flag_q) state_d = ST_HALT;
        else if (run)    state_d = ST_FETCH;
        else             state_d = ST_IDLE;
      end
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Status outputs registered from the next state so they line up with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start  <= 4'b0000;
      busy   <= 1'b0;
      halted <= 1'b0;
    end else begin
      start  <= phase_strobe(state_d);
      busy   <= (state_d != ST_IDLE) && (state_d != ST_HALT);
      halted <= (state_d == ST_HALT);
    end
  end

  // Halt flag: latched during DECODE/EXEC, forgotten when a new fetch begins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        halt_flag_q <= 1'b0;
    else if (enter_fetch)              halt_flag_q <= 1'b0;
    else if (sample_halt && halt_req)  halt_flag_q <= 1'b1;
  end

  // Branch redirect captured at EXEC exit, held through SETUP and WB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_update <= 1'b0;
      pc_o      <= '0;
    end else if (enter_fetch) begin
      pc_update <= 1'b0;
    end else if (state_q == ST_EXEC) begin
      pc_update <= branch_taken;
      if (branch_taken) pc_o <= branch_target;
    end
  end

  // Retire counter: one per WB exit, free-running wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 retired <= '0;
    else if (state_q == ST_WB)  retired <= retired + CNT_W'(1);
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
module tb_cpu_sequencer;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        step;
  logic        halt_req;
  logic        branch_taken;
  logic [31:0] branch_target;

  logic [3:0]  start,     start4;
  logic        pc_update, pc_update4;
  logic [31:0] pc_o,      pc_o4;
  logic        busy,      busy4;
  logic        halted,    halted4;
  logic [31:0] retired;
  logic [3:0]  retired4;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: instruction-level view of the sequencer
  int          m_phase;   // -1 = not executing, 0..4 = cycle within instruction
  bit          m_halted;
  bit          m_pend;
  bit          m_pcu;
  logic [31:0] m_pc;
  int          m_ret;

  cpu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step), .halt_req(halt_req),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .start(start), .pc_update(pc_update), .pc_o(pc_o), .busy(busy),
    .halted(halted), .retired(retired)
  );

  cpu_sequencer #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step), .halt_req(halt_req),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .start(start4), .pc_update(pc_update4), .pc_o(pc_o4), .busy(busy4),
    .halted(halted4), .retired(retired4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = -1; m_halted = 0; m_pend = 0; m_pcu = 0; m_pc = '0; m_ret = 0;
  endtask

  // Instruction cycles: fetch, decode, exec, setup, wb -> strobes 1,2,4,0,8
  function automatic logic [3:0] exp_start();
    if (m_phase < 0 || m_phase == 3) return 4'b0000;
    if (m_phase == 4) return 4'b1000;
    return 4'(1 << m_phase);
  endfunction

  task automatic model_edge();
    if (!rst_n) begin model_reset(); return; end
    if (m_halted) return;
    if (m_phase < 0) begin
      if (run || step) begin m_phase = 0; m_pend = 0; m_pcu = 0; end
      return;
    end
    case (m_phase)
      1: begin if (halt_req) m_pend = 1; m_phase = 2; end
      2: begin
        if (halt_req) m_pend = 1;
        m_pcu = branch_taken;
        if (branch_taken) m_pc = branch_target;
        m_phase = 3;
      end
      4: begin
        m_ret++;
        if (m_pend)   begin m_halted = 1; m_phase = -1; end
        else if (run) begin m_phase = 0; m_pend = 0; m_pcu = 0; end
        else          m_phase = -1;
      end
      default: m_phase++;
    endcase
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".start"},     32'(start),      32'(exp_start()));
    chk({tag, ".busy"},      32'(busy),       32'(m_phase >= 0));
    chk({tag, ".halted"},    32'(halted),     32'(m_halted));
    chk({tag, ".pc_update"}, 32'(pc_update),  32'(m_pcu));
    chk({tag, ".pc_o"},      pc_o,            m_pc);
    chk({tag, ".retired"},   retired,         32'(m_ret));
    chk({tag, ".start4"},    32'(start4),     32'(exp_start()));
    chk({tag, ".halted4"},   32'(halted4),    32'(m_halted));
    chk({tag, ".busy4"},     32'(busy4),      32'(m_phase >= 0));
    chk({tag, ".pc_o4"},     pc_o4,           m_pc);
    chk({tag, ".retired4"},  32'(retired4),   32'(m_ret & 15));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic run_until(input int ph, input int budget, input string tag);
    int n;
    n = 0;
    while (m_phase != ph && n < budget) begin
      tick(tag);
      n++;
    end
    if (m_phase != ph) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s timeout phase=%0d wanted=%0d", tag, m_phase, ph);
    end
  endtask

  // Asynchronous reset pulse issued between clock edges
  task automatic reset_pulse(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int base;
    rst_n = 1'b0; run = 1'b0; step = 1'b0; halt_req = 1'b0;
    branch_taken = 1'b0; branch_target = '0;
    model_reset();

    // Reset state, run held high while still in reset must not start
    #12;
    check_all("reset");
    run = 1'b1;
    tick("reset_hold");
    tick("reset_hold");
    rst_n = 1'b1;

    // Three back-to-back instructions, no branches
    for (int i = 0; i < 16; i++) tick("run3");
    chk("run3.retired_eq3", retired, 32'd3);

    // run drops during FETCH: instruction completes, then IDLE
    run = 1'b0;
    for (int i = 0; i < 5; i++) tick("run_fall");
    chk("run_fall.busy", 32'(busy), 32'd0);
    chk("run_fall.retired", retired, 32'd4);

    // Branch redirect in EXEC
    run = 1'b1;
    run_until(2, 8, "br_wait");
    branch_taken = 1'b1; branch_target = 32'h40;
    tick("br_setup");
    branch_taken = 1'b0; branch_target = 32'hDEAD_BEEF;
    chk("br_setup.pc_update", 32'(pc_update), 32'd1);
    chk("br_setup.pc_o", pc_o, 32'h40);
    tick("br_wb");
    chk("br_wb.pc_update", 32'(pc_update), 32'd1);
    chk("br_wb.start", 32'(start), 32'h8);
    tick("br_fetch");
    chk("br_fetch.pc_update", 32'(pc_update), 32'd0);
    chk("br_fetch.pc_o", pc_o, 32'h40);

    // Single step; a second step while busy is ignored
    run = 1'b0;
    run_until(-1, 8, "step_idle");
    base = m_ret;
    step = 1'b1;
    tick("step_fetch");
    step = 1'b0;
    chk("step_fetch.busy", 32'(busy), 32'd1);
    tick("step_decode");
    step = 1'b1;
    tick("step_exec");
    step = 1'b0;
    for (int i = 0; i < 5; i++) tick("step_tail");
    chk("step.retired", retired, 32'(base + 1));
    chk("step.busy", 32'(busy), 32'd0);

    // Halt requested in DECODE, plus a branch in EXEC of the same instruction
    run = 1'b1;
    run_until(1, 8, "halt_wait");
    halt_req = 1'b1;
    tick("halt_exec");
    halt_req = 1'b0; branch_taken = 1'b1; branch_target = 32'h80;
    tick("halt_setup");
    branch_taken = 1'b0;
    base = m_ret;
    tick("halt_wb");
    tick("halt_enter");
    chk("halt.halted", 32'(halted), 32'd1);
    chk("halt.pc_o", pc_o, 32'h80);
    chk("halt.retired", retired, 32'(base + 1));
    for (int i = 0; i < 6; i++) begin
      run = 1'($urandom); step = 1'($urandom);
      tick("halt_stay");
    end
    chk("halt.start", 32'(start), 32'd0);

    // Reset asserted while in EXEC
    step = 1'b0;
    reset_pulse("rst_leave_halt");
    run = 1'b1;
    run_until(2, 8, "rst_exec_wait");
    reset_pulse("rst_exec");
    tick("rst_restart");
    chk("rst_restart.start", 32'(start), 32'h1);

    // 17 instructions: 4-bit counter wraps 15 -> 0 -> 1
    reset_pulse("wrap_reset");
    for (int i = 1; i <= 86; i++) begin
      tick("wrap");
      if (i == 81) chk("wrap.zero", 32'(retired4), 32'd0);
    end
    chk("wrap.one", 32'(retired4), 32'd1);
    chk("wrap.wide", retired, 32'd17);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      run           = ($urandom_range(0, 3) != 0);
      step          = ($urandom_range(0, 4) == 0);
      halt_req      = ($urandom_range(0, 40) == 0);
      branch_taken  = 1'($urandom);
      branch_target = $urandom;
      if ((m_halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 150) == 0)
        reset_pulse("rnd_reset");
      tick("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
